mode7_affine_pipe: RTL and testbench
====================================

// Module: mode7_affine_pipe
// PURPOSE
//  Parametrised Mode7 pixel engine: per-scanline affine texture-coordinate stepping with selectable wrap mode.
//  Adds frame-synchronous shadow config, a texture RAM read port and a registered RGB output.
//  Sits between vga_sync and the pixel RGB register, driven by valueManager outputs.
//  Replaces the purely combinational per-pixel getXY path with a sequential incremental datapath.
// PARAMETERS
//  FRAC      8    fractional bits of all fixed-point config/accumulators
//  W         24   total signed width of matrix, origin, offset and accumulators (includes FRAC)
//  TEX_LOG2  6    texture is 2^TEX_LOG2 x 2^TEX_LOG2 texels
//  COLOR_W   8    texel/RGB width
//  H_ACTIVE  640  visible pixels per line
//  V_ACTIVE  480  visible lines
//  V_TOTAL   525  total lines per frame
//  MEM_LAT   1    clk cycles from tex_rd to valid tex_data; must be < clks per p_tick
// PORTS
//  clk           in   1          system clock
//  reset         in   1          synchronous, active-low reset
//  p_tick        in   1          pixel enable from vga_sync
//  video_on      in   1          active-video flag from vga_sync
//  pixel_x       in   10         current pixel column
//  pixel_y       in   10         current pixel row
//  cfg_a/b/c/d   in   W each     signed matrix terms (A,B,C,D), FRAC fixed-point
//  cfg_x0/y0     in   W each     signed rotation/scale origin
//  cfg_hofs/vofs in   W each     signed scroll offsets
//  cfg_mode      in   2          00 wrap, 01 clamp, 10 backdrop, 11 = wrap
//  cfg_backdrop  in   COLOR_W    colour for out-of-range texels in backdrop mode
//  tex_addr      out  2*TEX_LOG2 texel address {v,u}
//  tex_rd        out  1          1-clk read strobe
//  tex_data      in   COLOR_W    texel, valid MEM_LAT clks after tex_rd
//  rgb           out  COLOR_W    pixel colour
//  rgb_valid     out  1          rgb belongs to an active pixel
// BEHAVIOUR
//  Reset (reset==0 at clk edge): tex_addr=0, tex_rd=0, rgb=0, rgb_valid=0, accumulators X=Y=0.
//   Shadow regs reset to A=D=1<<FRAC, B=C=0, origins/offsets=0, mode=00, backdrop=0.
//  Shadow load: on p_tick with pixel_x==0 && pixel_y==V_ACTIVE, all cfg_* copied to shadow regs.
//   Live cfg changes at any other time have no effect until the next load.
//  Line setup: on p_tick with pixel_x==H_ACTIVE, ly = (pixel_y==V_TOTAL-1) ? 0 : pixel_y+1.
//   H = hofs - x0 and V = (ly<<FRAC) + vofs - y0.
//   X = A*H + B*V + x0 and Y = C*H + D*V + y0.
//   Products are signed W x W -> 2W, taking bits [W+FRAC-1:FRAC] (truncate); sums wrap mod 2^W.
//   A multi-cycle multiplier is allowed if it completes before the next line's pixel_x==0 tick.
//  Pixel step: on p_tick with video_on, stage the current X,Y; then X+=A and Y+=C (wrap mod 2^W).
//  Texel select: u = X[FRAC+TEX_LOG2-1:FRAC] and v likewise from Y.
//   oob = integer part of X or Y outside [0, 2^TEX_LOG2-1].
//   wrap: use u,v as-is.
//   clamp: negative -> 0, too large -> 2^TEX_LOG2-1, oob forced 0.
//   backdrop: u,v as wrap; oob carried down the pipe.
//  Read: tex_rd=1 for exactly the clk after the staging p_tick, with tex_addr={v,u}.
//   tex_addr holds until the next read.
//  Capture: MEM_LAT clks after tex_rd, hold <= (mode==10 && oob) ? backdrop : tex_data.
//  Output: on each p_tick, rgb <= hold if the previous tick was active video, else 0.
//   rgb_valid <= video_on from the previous tick.
//   Latency is exactly 1 pixel tick; rgb/rgb_valid change only on p_tick.
//  No tex_rd is issued when video_on==0; accumulators still advance only under video_on.
//  Simultaneous shadow load and line setup cannot occur (different pixel_x).
//   Line setup for ly=0 uses the freshly loaded shadow values.
//  Reset mid-frame clears state; the first correct line is the one after the next line setup.
// TESTING
//  Identity (A=D=0x100, B=C=0, offsets 0), line 3 -> pixel x=5 reads addr {6'd3,6'd5};
//   rgb==tex at tick+1, rgb_valid=1.
//  Scale A=0x200, line 0 -> successive tex_addr u = 0,2,4,...,62,0 (wrap at x=32).
//  hofs=-0x400 (-4.0), mode clamp -> x=0..3 give u=0, x=4 gives u=0, x=5 gives u=1.
//   Same stimulus in mode wrap gives u=60,61,62,63,0.
//  Mode backdrop, backdrop=0xE0, hofs=-0x400 -> rgb=0xE0 for x=0..3, texel data from x=4.
//  Change cfg_a to 0x080 mid-frame at line 100 -> lines 100..479 unchanged.
//   Next frame line 0 steps u by 0.5 per pixel.
//  Assert reset low for 3 clks at line 50, x=300 -> rgb=0, rgb_valid=0, tex_rd=0.
//   Shadow back to identity; line 51 matches identity output.

Source files
------------

// File: rtl/mode7_affine_pipe.sv
// Mode7 pixel engine: per-line affine setup, per-pixel incremental stepping,
// wrap/clamp/backdrop texel selection, texture read port and one-tick RGB output.
module mode7_affine_pipe #(
  parameter int FRAC     = 8,
  parameter int W        = 24,
  parameter int TEX_LOG2 = 6,
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int MEM_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p_tick,
  input  logic                    video_on,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic signed [W-1:0]     cfg_a,
  input  logic signed [W-1:0]     cfg_b,
  input  logic signed [W-1:0]     cfg_c,
  input  logic signed [W-1:0]     cfg_d,
  input  logic signed [W-1:0]     cfg_x0,
  input  logic signed [W-1:0]     cfg_y0,
  input  logic signed [W-1:0]     cfg_hofs,
  input  logic signed [W-1:0]     cfg_vofs,
  input  logic [1:0]              cfg_mode,
  input  logic [COLOR_W-1:0]      cfg_backdrop,
  output logic [2*TEX_LOG2-1:0]   tex_addr,
  output logic                    tex_rd,
  input  logic [COLOR_W-1:0]      tex_data,
  output logic [COLOR_W-1:0]      rgb,
  output logic                    rgb_valid
);

  localparam int TW = TEX_LOG2;
  localparam logic [TW-1:0] TMAX = '1;
  localparam logic signed [W-1:0] ONE = W'(1) << FRAC;

  logic signed [W-1:0] sh_a, sh_b, sh_c, sh_d, sh_x0, sh_y0, sh_hofs, sh_vofs;
  logic [1:0]          sh_mode;
  logic [COLOR_W-1:0]  sh_bd;

  logic signed [W-1:0] acc_x, acc_y;
  logic                stage_bd;
  logic [MEM_LAT-1:0]  rd_sr;
  logic [COLOR_W-1:0]  hold;
  logic                prev_active;

  logic shadow_load, line_setup, pix_step;
  assign shadow_load = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(V_ACTIVE));
  assign line_setup  = p_tick && (pixel_x == 10'(H_ACTIVE));
  assign pix_step    = p_tick && video_on;

  // Signed fixed-point multiply, truncating back to W bits at the FRAC point.
  function automatic logic signed [W-1:0] fx_mul(input logic signed [W-1:0] p,
                                                 input logic signed [W-1:0] q);
    logic signed [2*W-1:0] prod;
    prod = p * q;
    return W'(prod >>> FRAC);
  endfunction

  logic [9:0]          ly;
  logic signed [W-1:0] ly_fx, h_term, v_term, x_setup, y_setup;
  assign ly      = (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_y + 10'd1;
  assign ly_fx   = W'(ly) << FRAC;
  assign h_term  = sh_hofs - sh_x0;
  assign v_term  = ly_fx + sh_vofs - sh_y0;
  assign x_setup = fx_mul(sh_a, h_term) + fx_mul(sh_b, v_term) + sh_x0;
  assign y_setup = fx_mul(sh_c, h_term) + fx_mul(sh_d, v_term) + sh_y0;

  // Texel select from the coordinate currently being staged.
  logic          x_neg, x_big, y_neg, y_big, oob;
  logic [TW-1:0] u_sel, v_sel;
  assign x_neg = acc_x[W-1];
  assign y_neg = acc_y[W-1];
  assign x_big = !acc_x[W-1] && (|acc_x[W-2:FRAC+TW]);
  assign y_big = !acc_y[W-1] && (|acc_y[W-2:FRAC+TW]);
  assign oob   = x_neg || x_big || y_neg || y_big;

  always_comb begin
    u_sel = acc_x[FRAC+TW-1:FRAC];
    v_sel = acc_y[FRAC+TW-1:FRAC];
    if (sh_mode == 2'b01) begin
      if (x_neg)      u_sel = '0;
      else if (x_big) u_sel = TMAX;
      if (y_neg)      v_sel = '0;
      else if (y_big) v_sel = TMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_a    <= ONE;
      sh_b    <= '0;
      sh_c    <= '0;
      sh_d    <= ONE;
      sh_x0   <= '0;
      sh_y0   <= '0;
      sh_hofs <= '0;
      sh_vofs <= '0;
      sh_mode <= 2'b00;
      sh_bd   <= '0;
    end else if (shadow_load) begin
      sh_a    <= cfg_a;
      sh_b    <= cfg_b;
      sh_c    <= cfg_c;
      sh_d    <= cfg_d;
      sh_x0   <= cfg_x0;
      sh_y0   <= cfg_y0;
      sh_hofs <= cfg_hofs;
      sh_vofs <= cfg_vofs;
      sh_mode <= cfg_mode;
      sh_bd   <= cfg_backdrop;
    end
  end

  // Line setup and pixel stepping never coincide: setup happens at a blanked column.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_x <= '0;
      acc_y <= '0;
    end else if (line_setup) begin
      acc_x <= x_setup;
      acc_y <= y_setup;
    end else if (pix_step) begin
      acc_x <= acc_x + sh_a;
      acc_y <= acc_y + sh_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tex_rd   <= 1'b0;
      tex_addr <= '0;
      stage_bd <= 1'b0;
    end else begin
      tex_rd <= pix_step;
      if (pix_step) begin
        tex_addr <= {v_sel, u_sel};
        stage_bd <= (sh_mode == 2'b10) && oob;
      end
    end
  end

  // Read-latency tracker: the last bit marks the clk in which tex_data is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_sr <= '0;
      hold  <= '0;
    end else begin
      rd_sr[0] <= tex_rd;
      for (int i = 1; i < MEM_LAT; i++) rd_sr[i] <= rd_sr[i-1];
      if (rd_sr[MEM_LAT-1]) hold <= stage_bd ? sh_bd : tex_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb         <= '0;
      rgb_valid   <= 1'b0;
      prev_active <= 1'b0;
    end else if (p_tick) begin
      rgb         <= prev_active ? hold : '0;
      rgb_valid   <= prev_active;
      prev_active <= video_on;
    end
  end

endmodule

// File: tb/tb_mode7_affine_pipe.sv
// Directed bench for mode7_affine_pipe: table of config/line/pixel vectors with
// hand-computed texel addresses, plus reset, live-config and mid-frame-reset sequences.
module tb_mode7_affine_pipe;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          p_tick;
  logic          video_on;
  logic [9:0]    pixel_x, pixel_y;
  logic [W-1:0]  cfg_a, cfg_b, cfg_c, cfg_d, cfg_x0, cfg_y0, cfg_hofs, cfg_vofs;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_backdrop;
  logic [11:0]   tex_addr;
  logic          tex_rd;
  logic [7:0]    tex_data;
  logic [7:0]    rgb;
  logic          rgb_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic        snap_rd, snap_rd2, snap_vld;
  logic [11:0] snap_addr;
  logic [7:0]  snap_rgb;

  mode7_affine_pipe dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c), .cfg_d(cfg_d),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_hofs(cfg_hofs), .cfg_vofs(cfg_vofs),
    .cfg_mode(cfg_mode), .cfg_backdrop(cfg_backdrop),
    .tex_addr(tex_addr), .tex_rd(tex_rd), .tex_data(tex_data),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Texture RAM model: one-clk registered read.
  function automatic logic [7:0] tex_fn(input logic [11:0] a);
    return 8'(32'(a) * 37 + 11);
  endfunction

  always_ff @(posedge clk) tex_data <= tex_fn(tex_addr);

  // Scoreboard helper
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: one pixel tick then three idle clks; snapshots outputs after the tick edge.
  task automatic tick(input int x, input int y, input bit von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    p_tick   = 1'b1;
    @(posedge clk); #1;
    p_tick    = 1'b0;
    snap_rd   = tex_rd;
    snap_addr = tex_addr;
    snap_rgb  = rgb;
    snap_vld  = rgb_valid;
    @(posedge clk); #1;
    snap_rd2 = tex_rd;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [W-1:0] a, b, c, d, x0, y0, hofs, vofs,
                         input logic [1:0] mode, input logic [7:0] bd);
    cfg_a = a; cfg_b = b; cfg_c = c; cfg_d = d;
    cfg_x0 = x0; cfg_y0 = y0; cfg_hofs = hofs; cfg_vofs = vofs;
    cfg_mode = mode; cfg_backdrop = bd;
  endtask

  task automatic run_line(input int line, input int last_x);
    tick(640, (line == 0) ? 524 : line - 1, 1'b0);
    for (int x = 0; x <= last_x; x++) tick(x, line, 1'b1);
  endtask

  typedef struct {
    logic [W-1:0] a, b, c, d, x0, y0, hofs, vofs;
    logic [1:0]   mode;
    logic [7:0]   bd;
    int           line;
    int           px;
    logic [11:0]  exp_addr;
    bit           exp_bd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00, 8'h00, 3, 5, 12'd197, 1'b0};
    vecs[1]  = '{24'h200, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00, 8'h00, 0, 10, 12'd20, 1'b0};
    vecs[2]  = '{24'h200, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00, 8'h00, 0, 32, 12'd0, 1'b0};
    vecs[3]  = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'hFFFC00, 24'h0, 2'b01, 8'h00, 0, 2, 12'd0, 1'b0};
    vecs[4]  = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'hFFFC00, 24'h0, 2'b01, 8'h00, 0, 5, 12'd1, 1'b0};
    vecs[5]  = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'hFFFC00, 24'h0, 2'b00, 8'h00, 0, 1, 12'd61, 1'b0};
    vecs[6]  = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'hFFFC00, 24'h0, 2'b10, 8'hE0, 0, 2, 12'd62, 1'b1};
    vecs[7]  = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'hFFFC00, 24'h0, 2'b10, 8'hE0, 0, 4, 12'd0, 1'b0};
    vecs[8]  = '{24'h100, 24'h100, 24'h0, 24'h100, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00, 8'h00, 3, 10, 12'd205, 1'b0};
    vecs[9]  = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'h3C00, 24'h5000, 2'b01, 8'h00, 0, 10, 12'd4095, 1'b0};
    vecs[10] = '{24'h200, 24'h0, 24'h0, 24'h100, 24'h1000, 24'h1000, 24'h0, 24'h0, 2'b00, 8'h00, 0, 10, 12'd4, 1'b0};
    vecs[11] = '{24'h100, 24'h0, 24'hFFFF00, 24'h100, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00, 8'h00, 5, 3, 12'd131, 1'b0};
    vecs[12] = '{24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'hFFFC00, 24'h0, 2'b11, 8'h00, 0, 1, 12'd61, 1'b0};

    reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    set_cfg(24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check("reset_tex_addr", 32'(tex_addr), 32'd0);
    check("reset_tex_rd", 32'(tex_rd), 32'd0);
    check("reset_rgb", 32'(rgb), 32'd0);
    check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
    reset = 1'b1;

    // Reset shadow values are identity without any load.
    run_line(3, 5);
    check("rst_shadow_addr", 32'(snap_addr), 32'd197);
    tick(6, 3, 1'b0);
    check("rst_shadow_rgb", 32'(snap_rgb), 32'(tex_fn(12'd197)));

    for (int i = 0; i < 13; i++) begin
      logic [7:0] exp_rgb;
      set_cfg(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].x0, vecs[i].y0,
              vecs[i].hofs, vecs[i].vofs, vecs[i].mode, vecs[i].bd);
      tick(0, 480, 1'b0);
      run_line(vecs[i].line, vecs[i].px);
      exp_rgb = vecs[i].exp_bd ? vecs[i].bd : tex_fn(vecs[i].exp_addr);
      check($sformatf("v%0d_tex_rd", i), 32'(snap_rd), 32'd1);
      check($sformatf("v%0d_rd_pulse", i), 32'(snap_rd2), 32'd0);
      check($sformatf("v%0d_addr", i), 32'(snap_addr), 32'(vecs[i].exp_addr));
      tick(vecs[i].px + 1, vecs[i].line, 1'b0);
      check($sformatf("v%0d_rgb", i), 32'(snap_rgb), 32'(exp_rgb));
      check($sformatf("v%0d_rgb_valid", i), 32'(snap_vld), 32'd1);
      check($sformatf("v%0d_no_rd_blank", i), 32'(snap_rd), 32'd0);
      tick(vecs[i].px + 2, vecs[i].line, 1'b0);
      check($sformatf("v%0d_rgb_blank", i), 32'(snap_rgb), 32'd0);
      check($sformatf("v%0d_valid_blank", i), 32'(snap_vld), 32'd0);
    end

    // Live cfg change mid-frame has no effect until the next shadow load.
    set_cfg(24'h100, 24'h0, 24'h0, 24'h100, 24'h0, 24'h0, 24'h0, 24'h0, 2'b00, 8'h00);
    tick(0, 480, 1'b0);
    tick(640, 99, 1'b0);
    cfg_a = 24'h080;
    for (int x = 0; x <= 6; x++) tick(x, 100, 1'b1);
    check("live_line100_addr", 32'(snap_addr), 32'd2310);
    run_line(101, 4);
    check("live_line101_addr", 32'(snap_addr), 32'd2372);
    tick(0, 480, 1'b0);
    run_line(0, 1);
    check("half_step_x1", 32'(snap_addr), 32'd0);
    for (int x = 2; x <= 9; x++) tick(x, 0, 1'b1);
    check("half_step_x9", 32'(snap_addr), 32'd4);

    // Mid-frame reset at line 50, x=300; live cfg left non-identity.
    cfg_a = 24'h200;
    tick(0, 480, 1'b0);
    run_line(50, 300);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_tex_rd", 32'(tex_rd), 32'd0);
    check("midrst_rgb", 32'(rgb), 32'd0);
    check("midrst_rgb_valid", 32'(rgb_valid), 32'd0);
    check("midrst_tex_addr", 32'(tex_addr), 32'd0);
    reset = 1'b1;
    run_line(51, 7);
    check("post_rst_addr", 32'(snap_addr), 32'd3271);
    tick(8, 51, 1'b0);
    check("post_rst_rgb", 32'(snap_rgb), 32'(tex_fn(12'd3271)));
    check("post_rst_valid", 32'(snap_vld), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
